// File: rtl/sha256_stream_core_if.sv
// Block-stream port bundle for sha256_stream_core: message control, block
// handshake and digest result, with the core as slave and the feeder as master.
interface sha256_stream_core_if;
  logic                  start;
  logic                  iv_sel;
  logic [7:0][31:0]      iv_in;
  // A block transfers on every rising edge where blk_valid && blk_ready; the
  // master holds blk_data/blk_last stable while blk_valid is high and unaccepted.
  logic                  blk_valid;
  logic                  blk_ready;
  logic [15:0][31:0]     blk_data;
  logic                  blk_last;
  logic                  abort;
  logic                  busy;
  logic                  hash_valid;
  logic [7:0][31:0]      hash_out;

  modport master (
    output start, iv_sel, iv_in, blk_valid, blk_data, blk_last, abort,
    input  blk_ready, busy, hash_valid, hash_out
  );

  modport slave (
    input  start, iv_sel, iv_in, blk_valid, blk_data, blk_last, abort,
    output blk_ready, busy, hash_valid, hash_out
  );
endinterface

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 compression engine: chains the hash across a stream of
// pre-padded 512-bit blocks, running ROUNDS_PER_CYCLE rounds per clock.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha256_stream_core_if.slave  bus,
  output logic [1:0]           state_dbg_o
);
  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] T_LAST = 6'(64 - R);

  if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
    $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT_BLK, S_COMPUTE, S_FINAL} state_e;

  localparam logic [7:0][31:0] IV_STD = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [7:0][31:0] round_step(input logic [7:0][31:0] s,
                                                   input logic [31:0] k,
                                                   input logic [31:0] w);
    logic [31:0] t1, t2;
    logic [7:0][31:0] n;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
       + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
       + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    n[0] = t1 + t2;
    n[1] = s[0];
    n[2] = s[1];
    n[3] = s[2];
    n[4] = s[3] + t1;
    n[5] = s[4];
    n[6] = s[5];
    n[7] = s[6];
    return n;
  endfunction

  // Rounds t..t+R-1 only consume w[0..R-1], so the window is read directly.
  function automatic logic [7:0][31:0] run_rounds(input logic [7:0][31:0] work,
                                                   input logic [15:0][31:0] w,
                                                   input logic [5:0] t);
    logic [7:0][31:0] st;
    st = work;
    for (int r = 0; r < R; r++) st = round_step(st, K_TAB[t + 6'(r)], w[r]);
    return st;
  endfunction

  function automatic logic [15:0][31:0] next_window(input logic [15:0][31:0] w);
    logic [31:0] ext [16+R];
    logic [15:0][31:0] o;
    for (int i = 0; i < 16; i++) ext[i] = w[i];
    for (int r = 0; r < R; r++)
      ext[16+r] = ext[r] + ssig0(ext[r+1]) + ext[r+9] + ssig1(ext[r+14]);
    for (int i = 0; i < 16; i++) o[i] = ext[i+R];
    return o;
  endfunction

  state_e            state_q, state_d;
  logic [7:0][31:0]  hash_q, hash_d;
  logic [7:0][31:0]  work_q, work_d;
  logic [15:0][31:0] w_q, w_d;
  logic [5:0]        t_q, t_d;
  logic              last_q, last_d;
  logic [7:0][31:0]  hash_out_q, hash_out_d;
  logic              hash_valid_q, hash_valid_d;

  always_comb begin
    state_d      = state_q;
    hash_d       = hash_q;
    work_d       = work_q;
    w_d          = w_q;
    t_d          = t_q;
    last_d       = last_q;
    hash_out_d   = hash_out_q;
    hash_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          hash_d  = bus.iv_sel ? bus.iv_in : IV_STD;
          state_d = S_WAIT_BLK;
        end
      end
      S_WAIT_BLK: begin
        // abort wins: a block offered in the same cycle stays with the sender.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (bus.blk_valid) begin
          work_d  = hash_q;
          w_d     = bus.blk_data;
          last_d  = bus.blk_last;
          t_d     = '0;
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          work_d = run_rounds(work_q, w_q, t_q);
          w_d    = next_window(w_q);
          t_d    = t_q + 6'(R);
          if (t_q == T_LAST) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          for (int n = 0; n < 8; n++) hash_d[n] = hash_q[n] + work_q[n];
          if (last_q) begin
            hash_out_d   = hash_d;
            hash_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            state_d = S_WAIT_BLK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      hash_out_q   <= '0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hash_out_q   <= hash_out_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  // Datapath registers are qualified by state, so they need no reset.
  always_ff @(posedge clk) begin
    hash_q <= hash_d;
    work_q <= work_d;
    w_q    <= w_d;
    t_q    <= t_d;
    last_q <= last_d;
  end

  assign bus.blk_ready  = (state_q == S_WAIT_BLK);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.hash_valid = hash_valid_q;
  assign bus.hash_out   = hash_out_q;
  assign state_dbg_o    = state_q;
endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: four instances (1/2/4/8 rounds per cycle)
// driven from a vector table, control corner cases and a random chained model.
module tb_sha256_stream_core;
  typedef logic [7:0][31:0]  hash_t;
  typedef logic [15:0][31:0] blk_t;

  typedef struct {
    int    dut;
    logic  iv_sel;
    hash_t iv;
    int    nblk;
    blk_t  blks [4];
    int    gap;
    bit    poke;
    hash_t exp_dig;
    string name;
  } vec_t;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [255:0] exp_q[$];

  logic  start_a [4];
  logic  iv_sel_a [4];
  hash_t iv_a [4];
  logic  valid_a [4];
  blk_t  data_a [4];
  logic  last_a [4];
  logic  abort_a [4];
  logic  ready_a [4];
  logic  busy_a [4];
  logic  hv_a [4];
  hash_t hout_a [4];
  logic [1:0] dbg_a [4];
  int    hv_cnt [4] = '{0, 0, 0, 0};

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_stream_core_if u_if ();
    sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (u_if.slave),
      .state_dbg_o (dbg_a[g])
    );
    assign u_if.start     = start_a[g];
    assign u_if.iv_sel    = iv_sel_a[g];
    assign u_if.iv_in     = iv_a[g];
    assign u_if.blk_valid = valid_a[g];
    assign u_if.blk_data  = data_a[g];
    assign u_if.blk_last  = last_a[g];
    assign u_if.abort     = abort_a[g];
    assign ready_a[g]     = u_if.blk_ready;
    assign busy_a[g]      = u_if.busy;
    assign hv_a[g]        = u_if.hash_valid;
    assign hout_a[g]      = u_if.hash_out;
  end

  always @(negedge clk)
    for (int i = 0; i < 4; i++) if (hv_a[i] === 1'b1) hv_cnt[i]++;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] xx;
    xx = {x, x};
    return xx[n +: 32];
  endfunction

  function automatic hash_t sha_compress(input hash_t h, input blk_t b);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    hash_t o;
    for (int t = 0; t < 16; t++) w[t] = b[t];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) o[i] = h[i] + v[i];
    return o;
  endfunction

  function automatic hash_t h8(input logic [255:0] be);
    hash_t o;
    for (int i = 0; i < 8; i++) o[i] = be[255-32*i -: 32];
    return o;
  endfunction

  function automatic blk_t b16(input logic [511:0] be);
    blk_t o;
    for (int i = 0; i < 16; i++) o[i] = be[511-32*i -: 32];
    return o;
  endfunction

  function automatic vec_t mkvec(input int dut, input logic iv_sel, input hash_t iv,
                                 input int nblk, input blk_t b0, input blk_t b1,
                                 input int gap, input bit poke, input hash_t exp_dig,
                                 input string name);
    vec_t v;
    v.dut = dut; v.iv_sel = iv_sel; v.iv = iv; v.nblk = nblk;
    v.blks[0] = b0; v.blks[1] = b1; v.blks[2] = '0; v.blks[3] = '0;
    v.gap = gap; v.poke = poke; v.exp_dig = exp_dig; v.name = name;
    return v;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check_dig(input string name, input hash_t act, input hash_t exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_msg(input vec_t v, output hash_t dig);
    int d, per, k, c0;
    d = v.dut;
    per = 64 / (1 << d) + 2;
    c0 = hv_cnt[d];
    dig = '0;
    @(negedge clk);
    start_a[d] = 1'b1; iv_sel_a[d] = v.iv_sel; iv_a[d] = v.iv;
    @(negedge clk);
    start_a[d] = 1'b0; iv_sel_a[d] = 1'b0; iv_a[d] = '0;
    check_int({v.name, "_ready_after_start"}, int'(ready_a[d]), 1);
    for (int b = 0; b < v.nblk; b++) begin
      data_a[d] = v.blks[b]; last_a[d] = (b == v.nblk - 1); valid_a[d] = 1'b1;
      @(negedge clk);
      valid_a[d] = 1'b0; last_a[d] = 1'b0;
      k = 1;
      if (v.poke && b == 0) begin
        start_a[d] = 1'b1; iv_sel_a[d] = 1'b1;
        for (int i = 0; i < 8; i++) iv_a[d][i] = $urandom;
        @(negedge clk);
        k++;
        start_a[d] = 1'b0; iv_sel_a[d] = 1'b0; iv_a[d] = '0;
        check_int({v.name, "_busy_during_poke"}, int'(busy_a[d]), 1);
      end
      if (b < v.nblk - 1) begin
        while (ready_a[d] !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check_int({v.name, "_ready_latency"}, k, per);
        repeat (v.gap) @(negedge clk);
      end else begin
        while (hv_a[d] !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check_int({v.name, "_valid_latency"}, k, per);
        check_int({v.name, "_busy_at_valid"}, int'(busy_a[d]), 0);
        dig = hout_a[d];
        @(negedge clk);
        check_int({v.name, "_valid_pulse"}, int'(hv_a[d]), 0);
      end
    end
    check_int({v.name, "_pulse_count"}, hv_cnt[d] - c0, 1);
  endtask

  // ---------------- test ----------------
  initial begin
    hash_t iv_std, d_empty, d_abc, d_two, mid, dig, h, last_dig0;
    blk_t  b_empty, b_abc, b_two1, b_two2;
    vec_t  vecs [10];
    vec_t  rv;
    int    c0, k;

    iv_std  = h8(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);
    d_empty = h8(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
    d_abc   = h8(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
    d_two   = h8(256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1);
    b_empty = '0; b_empty[0] = 32'h80000000;
    b_abc = '0; b_abc[0] = 32'h61626380; b_abc[15] = 32'h00000018;
    b_two1 = b16({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
    b_two2 = '0; b_two2[15] = 32'h000001c0;
    mid = sha_compress(iv_std, b_two1);

    for (int i = 0; i < 4; i++) begin
      start_a[i] = 1'b0; iv_sel_a[i] = 1'b0; iv_a[i] = '0; valid_a[i] = 1'b0;
      data_a[i] = '0; last_a[i] = 1'b0; abort_a[i] = 1'b0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_int("reset_busy", int'(busy_a[i]), 0);
      check_int("reset_ready", int'(ready_a[i]), 0);
      check_int("reset_hash_valid", int'(hv_a[i]), 0);
      check_dig("reset_hash_out", hout_a[i], '0);
    end
    reset_n = 1'b1;

    vecs[0] = mkvec(0, 1'b0, '0, 1, b_empty, '0, 0, 1'b0, d_empty, "empty");
    vecs[1] = mkvec(0, 1'b0, '0, 1, b_abc, '0, 0, 1'b0, d_abc, "abc_r1");
    vecs[2] = mkvec(1, 1'b0, '0, 1, b_abc, '0, 0, 1'b0, d_abc, "abc_r2");
    vecs[3] = mkvec(2, 1'b0, '0, 1, b_abc, '0, 0, 1'b0, d_abc, "abc_r4");
    vecs[4] = mkvec(3, 1'b0, '0, 1, b_abc, '0, 0, 1'b0, d_abc, "abc_r8");
    vecs[5] = mkvec(0, 1'b0, '0, 2, b_two1, b_two2, 3, 1'b0, d_two, "two_block_r1");
    vecs[6] = mkvec(3, 1'b0, '0, 2, b_two1, b_two2, 0, 1'b0, d_two, "two_block_r8");
    vecs[7] = mkvec(2, 1'b0, '0, 1, b_two1, '0, 0, 1'b0, mid, "mid_capture");
    vecs[8] = mkvec(2, 1'b1, mid, 1, b_two2, '0, 0, 1'b0, d_two, "midstate");
    vecs[9] = mkvec(1, 1'b0, '0, 1, b_abc, '0, 0, 1'b1, d_abc, "start_while_busy");

    last_dig0 = '0;
    for (int i = 0; i < 10; i++) begin
      run_msg(vecs[i], dig);
      check_dig({vecs[i].name, "_digest"}, dig, vecs[i].exp_dig);
      if (vecs[i].dut == 0) last_dig0 = vecs[i].exp_dig;
    end

    // abort mid-COMPUTE: no digest, previous hash_out held
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    data_a[0] = b_abc; last_a[0] = 1'b1; valid_a[0] = 1'b1;
    @(negedge clk); valid_a[0] = 1'b0; last_a[0] = 1'b0;
    repeat (10) @(negedge clk);
    check_int("abort_busy_before", int'(busy_a[0]), 1);
    c0 = hv_cnt[0];
    abort_a[0] = 1'b1;
    @(negedge clk); abort_a[0] = 1'b0;
    check_int("abort_busy_after", int'(busy_a[0]), 0);
    repeat (80) @(negedge clk);
    check_int("abort_no_valid", hv_cnt[0] - c0, 0);
    check_dig("abort_hash_held", hout_a[0], last_dig0);

    // abort beats a simultaneous handshake; the held block waits through IDLE
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    data_a[0] = b_empty; last_a[0] = 1'b1; valid_a[0] = 1'b1; abort_a[0] = 1'b1;
    @(negedge clk); abort_a[0] = 1'b0;
    check_int("abort_hs_busy", int'(busy_a[0]), 0);
    repeat (4) @(negedge clk);
    check_int("idle_hold_ready", int'(ready_a[0]), 0);
    check_int("idle_hold_busy", int'(busy_a[0]), 0);
    start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    check_int("held_ready_in_wait", int'(ready_a[0]), 1);
    @(negedge clk); valid_a[0] = 1'b0; last_a[0] = 1'b0;
    k = 1;
    check_int("held_consumed_ready", int'(ready_a[0]), 0);
    check_int("held_consumed_busy", int'(busy_a[0]), 1);
    while (hv_a[0] !== 1'b1 && k < 400) begin @(negedge clk); k++; end
    check_int("held_valid_latency", k, 66);
    check_dig("held_digest", hout_a[0], d_empty);

    // asynchronous reset mid-COMPUTE
    @(negedge clk); start_a[0] = 1'b1;
    @(negedge clk); start_a[0] = 1'b0;
    data_a[0] = b_two1; last_a[0] = 1'b1; valid_a[0] = 1'b1;
    @(negedge clk); valid_a[0] = 1'b0; last_a[0] = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_int("async_rst_busy", int'(busy_a[i]), 0);
      check_int("async_rst_ready", int'(ready_a[i]), 0);
      check_int("async_rst_valid", int'(hv_a[i]), 0);
      check_dig("async_rst_hash_out", hout_a[i], '0);
    end
    @(negedge clk); reset_n = 1'b1;
    run_msg(vecs[1], dig);
    check_dig("post_reset_abc_digest", dig, d_abc);

    // random chained messages against the model
    for (int d = 0; d < 4; d++) begin
      for (int m = 0; m < 3; m++) begin
        rv.dut = d;
        rv.iv_sel = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) rv.iv[i] = $urandom;
        rv.nblk = $urandom_range(1, 3);
        rv.gap = $urandom_range(0, 2);
        rv.poke = 1'b0;
        rv.name = "rand";
        h = rv.iv_sel ? rv.iv : iv_std;
        for (int b = 0; b < 4; b++) begin
          for (int i = 0; i < 16; i++) rv.blks[b][i] = $urandom;
          if (b < rv.nblk) h = sha_compress(h, rv.blks[b]);
        end
        rv.exp_dig = h;
        exp_q.push_back(h);
        run_msg(rv, dig);
        check_dig("rand_digest", dig, exp_q.pop_front());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
